// File: rtl/act_relu_fifo.sv
// Elastic activation FIFO with optional ReLU on write and first-word fall-through read.
// Define ACT_FIFO_LAST_EN to add per-entry frame-end tagging and the output_last port.
module act_relu_fifo #(
  parameter int T     = 20,
  parameter int M     = 16,
  parameter int DEPTH = 16,
  parameter int RELU  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     input_valid,
  output logic                     input_ready,
  input  logic [T-1:0]             input_data,
  output logic                     output_valid,
  input  logic                     output_ready,
  output logic [T-1:0]             output_data,
  output logic [$clog2(DEPTH):0]   fill_count
`ifdef ACT_FIFO_LAST_EN
  ,
  output logic                     output_last
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (M < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("act_relu_fifo: M must be >= 1 and DEPTH a power of 2 >= 2");
  end

  logic [T-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [T-1:0]  wdata;

  assign input_ready  = (fill_count != CW'(DEPTH));
  assign output_valid = (fill_count != '0);
  assign push         = input_valid & input_ready;
  assign pop          = output_valid & output_ready;
  assign wdata        = (RELU != 0 && input_data[T-1]) ? '0 : input_data;
  assign output_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill_count <= fill_count + 1'b1;
        2'b01:   fill_count <= fill_count - 1'b1;
        default: fill_count <= fill_count;
      endcase
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

`ifdef ACT_FIFO_LAST_EN
  localparam int FW = (M > 1) ? $clog2(M) : 1;

  logic          last_mem [DEPTH];
  logic [FW-1:0] frame_idx;
  logic          frame_end;

  assign frame_end   = (frame_idx == FW'(M - 1));
  assign output_last = output_valid & last_mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_idx <= '0;
    end else if (push) begin
      frame_idx <= frame_end ? '0 : frame_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) last_mem[wr_ptr] <= frame_end;
  end
`endif

endmodule

// File: tb/tb_act_relu_fifo.sv
// Scoreboard bench for act_relu_fifo: directed pushes queue hand-computed results,
// a negedge monitor pops and compares on every output handshake.
module tb_act_relu_fifo;

  localparam int T     = 20;
  localparam int M     = 16;
  localparam int DEPTH = 16;

  typedef struct {
    logic [T-1:0] d;
    logic         l;
  } exp_t;

  logic         clk = 0;
  logic         reset = 0;
  logic         input_valid = 0;
  logic         input_ready;
  logic [T-1:0] input_data = '0;
  logic         output_valid;
  logic         output_ready = 0;
  logic [T-1:0] output_data;
  logic [4:0]   fill_count;
  logic         output_last;

  logic         r_in_valid = 0;
  logic         r_in_ready;
  logic [T-1:0] r_in_data = '0;
  logic         r_out_valid;
  logic [T-1:0] r_out_data;
  logic [4:0]   r_fill;
  logic         r_last;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_last   = 0;

  always #5 clk = ~clk;

  act_relu_fifo #(.T(T), .M(M), .DEPTH(DEPTH), .RELU(1)) u_dut (
    .clk(clk), .reset(reset),
    .input_valid(input_valid), .input_ready(input_ready), .input_data(input_data),
    .output_valid(output_valid), .output_ready(output_ready), .output_data(output_data),
    .fill_count(fill_count)
`ifdef ACT_FIFO_LAST_EN
    , .output_last(output_last)
`endif
  );

  act_relu_fifo #(.T(T), .M(M), .DEPTH(DEPTH), .RELU(0)) u_raw (
    .clk(clk), .reset(reset),
    .input_valid(r_in_valid), .input_ready(r_in_ready), .input_data(r_in_data),
    .output_valid(r_out_valid), .output_ready(1'b0), .output_data(r_out_data),
    .fill_count(r_fill)
`ifdef ACT_FIFO_LAST_EN
    , .output_last(r_last)
`endif
  );

`ifndef ACT_FIFO_LAST_EN
  assign output_last = 1'b0;
  assign r_last      = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor / scoreboard: every accepted output word is compared with the queue head.
  always @(negedge clk) begin
    if (reset && output_valid && output_ready) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL pop_unexpected: got %0h, expected no output", output_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pop_data", 32'(output_data), 32'(e.d));
`ifdef ACT_FIFO_LAST_EN
        chk("pop_last", 32'(output_last), 32'(e.l));
        if (output_last) n_last++;
`endif
      end
    end
  end

  task automatic push_val(input int v, input int e, input logic l = 1'b0);
    int   n;
    exp_t x;
    n = 0;
    input_valid = 1'b1;
    input_data  = v[T-1:0];
    @(negedge clk);
    while (!input_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!input_ready) begin
      n_checks++;
      $display("FAIL push_timeout: got input_ready=0, expected 1 within 50 cycles");
    end else begin
      x.d = e[T-1:0];
      x.l = l;
      q.push_back(x);
    end
    @(posedge clk);
    #1;
    input_valid = 1'b0;
  endtask

  task automatic drain();
    output_ready = 1'b1;
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", 32'(q.size()), 32'd0);
    chk("drain_valid", 32'(output_valid), 32'd0);
    output_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(output_valid), 32'd0);
    chk("rst_in_ready", 32'(input_ready), 32'd1);
    chk("rst_fill", 32'(fill_count), 32'd0);
    chk("rst_last", 32'(output_last), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // 1: ReLU clamps the negative entry; fill tracks pushes while stalled
    push_val(5, 5);
    push_val(-7, 0);
    push_val(300, 300);
    chk("t1_fill", 32'(fill_count), 32'd3);
    chk("t1_head", 32'(output_data), 32'd5);
    drain();

    // 2: pass-through instance keeps the negative value
    r_in_valid = 1'b1;
    r_in_data  = 20'hFFFF9;
    @(posedge clk);
    #1;
    r_in_valid = 1'b0;
    chk("t2_valid", 32'(r_out_valid), 32'd1);
    chk("t2_data", 32'(r_out_data), 32'h000FFFF9);
    chk("t2_fill", 32'(r_fill), 32'd1);

    // 3: fill to DEPTH, 17th word held off until a pop frees a slot
    for (int i = 0; i < 16; i++) push_val(i * 3 - 20, (i * 3 - 20 < 0) ? 0 : i * 3 - 20);
    chk("t3_fill_full", 32'(fill_count), 32'd16);
    chk("t3_ready_full", 32'(input_ready), 32'd0);
    input_valid = 1'b1;
    input_data  = 20'd777;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("t3_held_fill", 32'(fill_count), 32'd16);
    end
    output_ready = 1'b1;
    @(posedge clk);
    #1;
    output_ready = 1'b0;
    chk("t3_ready_after_pop", 32'(input_ready), 32'd1);
    chk("t3_fill_after_pop", 32'(fill_count), 32'd15);
    push_val(777, 777);
    chk("t3_refill", 32'(fill_count), 32'd16);
    drain();

    // 4: simultaneous push/pop at fill 4 across pointer wrap
    for (int i = 0; i < 4; i++) push_val(10 + i, 10 + i);
    output_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_val(20 + i, 20 + i);
      chk("t4_fill_steady", 32'(fill_count), 32'd4);
    end
    drain();

    // 5: asynchronous reset mid-stream drops buffered words
    for (int i = 0; i < 9; i++) push_val(i + 1, i + 1);
    chk("t5_fill9", 32'(fill_count), 32'd9);
    @(posedge clk);
    #2;
    reset = 1'b0;
    q.delete();
    #1;
    chk("t5_valid_rst", 32'(output_valid), 32'd0);
    chk("t5_fill_rst", 32'(fill_count), 32'd0);
    chk("t5_ready_rst", 32'(input_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    push_val(42, 42);
    chk("t5_data42", 32'(output_data), 32'd42);
    chk("t5_valid42", 32'(output_valid), 32'd1);
    drain();

`ifdef ACT_FIFO_LAST_EN
    // 6: frame-end tags on the 16th and 32nd words
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_last = 0;
    output_ready = 1'b1;
    for (int i = 0; i < 32; i++) push_val(i + 1, i + 1, (i % 16) == 15);
    drain();
    chk("t6_last_count", 32'(n_last), 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
